// File: rtl/wbq_pkg.sv
// Shared definitions for the write-back queue.
//   WBQ_DEPTH / WBQ_DATA_W / WBQ_ADDR_W : default queue geometry
//   ZERO_REG                            : architectural zero register index; writes
//                                         to it are dropped and it never forwards
//   wbq_cnt_w()                         : width of an occupancy counter for a depth
package wbq_pkg;

  localparam int unsigned WBQ_DEPTH  = 4;
  localparam int unsigned WBQ_DATA_W = 32;
  localparam int unsigned WBQ_ADDR_W = 5;
  localparam int unsigned ZERO_REG   = 0;

  // The counter must hold the value DEPTH itself, hence one bit more than the pointers.
  function automatic int unsigned wbq_cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/wbq_forward.sv
// Youngest-match forwarding search over the pending-write entries.
//   en_i          : lookup enable (low forces a miss)
//   lookup_reg_i  : register index being looked up
//   entry_reg_i   : entry register indices, element 0 = oldest, N-1 = youngest
//   entry_data_i  : entry data, same ordering
//   entry_vld_i   : entry occupied flags, same ordering
//   hit_o         : an occupied entry matches a non-zero lookup index
//   data_o        : data of the youngest matching entry, 0 on a miss
module wbq_forward
  import wbq_pkg::*;
#(
  parameter int unsigned N      = WBQ_DEPTH,
  parameter int unsigned DATA_W = WBQ_DATA_W,
  parameter int unsigned ADDR_W = WBQ_ADDR_W
) (
  input  logic                          en_i,
  input  logic [ADDR_W-1:0]             lookup_reg_i,
  input  logic [N-1:0][ADDR_W-1:0]      entry_reg_i,
  input  logic [N-1:0][DATA_W-1:0]      entry_data_i,
  input  logic [N-1:0]                  entry_vld_i,
  output logic                          hit_o,
  output logic [DATA_W-1:0]             data_o
);

  // Scanning oldest to youngest and letting each later match overwrite the
  // result gives the youngest match priority.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    if (en_i && (lookup_reg_i != ADDR_W'(ZERO_REG))) begin
      for (int k = 0; k < int'(N); k++) begin
        if (entry_vld_i[k] && (entry_reg_i[k] == lookup_reg_i)) begin
          hit_o  = 1'b1;
          data_o = entry_data_i[k];
        end
      end
    end
  end

endmodule

// File: rtl/write_back_queue.sv
// Write-back queue: buffers register-file writes in FIFO order, drains one per
// cycle into the register-file write port, and forwards the newest pending value
// for two lookup indices.
//   CLK, Reset              : clock, synchronous active-high reset
//   InValid/InReady         : request handshake; InReg/InData carry the request
//   WbStall                 : write port busy, head is held
//   RegWre/WriteReg/WriteData : register-file write of the head entry
//   LookupReg1/2            : forwarding lookup indices
//   Hit1/2, FwdData1/2      : forwarding results
//   Count                   : number of occupied entries
//
// Handshake: a request transfers on the rising edge where InValid && InReady.
// InReady depends only on registered occupancy and Reset, never on InValid.
// Accepted requests targeting the zero register are consumed but not stored.
// The head is written (and popped) on the edge where RegWre is high.
module write_back_queue
  import wbq_pkg::*;
#(
  parameter  int unsigned DEPTH  = WBQ_DEPTH,
  parameter  int unsigned DATA_W = WBQ_DATA_W,
  parameter  int unsigned ADDR_W = WBQ_ADDR_W,
  localparam int unsigned PTR_W  = $clog2(DEPTH),
  localparam int unsigned CNT_W  = wbq_cnt_w(DEPTH)
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              InValid,
  output logic              InReady,
  input  logic [ADDR_W-1:0] InReg,
  input  logic [DATA_W-1:0] InData,
  input  logic              WbStall,
  output logic              RegWre,
  output logic [ADDR_W-1:0] WriteReg,
  output logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] LookupReg1,
  input  logic [ADDR_W-1:0] LookupReg2,
  output logic              Hit1,
  output logic              Hit2,
  output logic [DATA_W-1:0] FwdData1,
  output logic [DATA_W-1:0] FwdData2,
  output logic [CNT_W-1:0]  Count
);

  // Entry storage is deliberately not reset; occupancy alone decides visibility.
  logic [ADDR_W-1:0] reg_mem_q  [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic push;
  logic pop;

  assign InReady   = (count_q < CNT_W'(DEPTH)) && !Reset;
  assign push      = InValid && InReady && (InReg != ADDR_W'(ZERO_REG));
  assign RegWre    = (count_q != '0) && !WbStall && !Reset;
  assign pop       = RegWre;
  assign WriteReg  = reg_mem_q[rd_ptr_q];
  assign WriteData = data_mem_q[rd_ptr_q];
  assign Count     = count_q;

  // Pointers are exactly PTR_W bits wide, so DEPTH being a power of two makes
  // the natural overflow the modulo-DEPTH wrap.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // push is already false while Reset is high (InReady is gated).
  always_ff @(posedge CLK) begin
    if (push) begin
      reg_mem_q[wr_ptr_q]  <= InReg;
      data_mem_q[wr_ptr_q] <= InData;
    end
  end

  // Present the entries in age order (head first) so the search can use
  // position as age. The head stays occupied until the pop edge, so it is
  // still visible during its own write cycle; a request being accepted now is
  // not yet counted and so is not visible.
  logic [DEPTH-1:0][ADDR_W-1:0] ord_reg;
  logic [DEPTH-1:0][DATA_W-1:0] ord_data;
  logic [DEPTH-1:0]             ord_vld;

  always_comb begin
    for (int k = 0; k < int'(DEPTH); k++) begin
      ord_reg[k]  = reg_mem_q[rd_ptr_q + PTR_W'(k)];
      ord_data[k] = data_mem_q[rd_ptr_q + PTR_W'(k)];
      ord_vld[k]  = (CNT_W'(k) < count_q);
    end
  end

  wbq_forward #(
    .N      (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fwd1 (
    .en_i         (!Reset),
    .lookup_reg_i (LookupReg1),
    .entry_reg_i  (ord_reg),
    .entry_data_i (ord_data),
    .entry_vld_i  (ord_vld),
    .hit_o        (Hit1),
    .data_o       (FwdData1)
  );

  wbq_forward #(
    .N      (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fwd2 (
    .en_i         (!Reset),
    .lookup_reg_i (LookupReg2),
    .entry_reg_i  (ord_reg),
    .entry_data_i (ord_data),
    .entry_vld_i  (ord_vld),
    .hit_o        (Hit2),
    .data_o       (FwdData2)
  );

endmodule

// File: doc/write_back_queue.md
WRITE_BACK_QUEUE -- requirements
Module: write_back_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of pending-write entries (power of 2, at least 2).
REQ-002 SHALL have parameter DATA_W, default 32, register data width.
REQ-003 SHALL have parameter ADDR_W, default 5, register index width.
REQ-004 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port InValid  input  1  write request valid.
REQ-007 SHALL have port InReady  output  1  queue can accept a request this cycle.
REQ-008 SHALL have port InReg  input  ADDR_W  destination register of the request.
REQ-009 SHALL have port InData  input  DATA_W  data of the request.
REQ-010 SHALL have port WbStall  input  1  register-file write port unavailable; hold head.
REQ-011 SHALL have port RegWre  output  1  register-file write enable.
REQ-012 SHALL have port WriteReg  output  ADDR_W  register-file write index.
REQ-013 SHALL have port WriteData  output  DATA_W  register-file write data.
REQ-014 SHALL have ports LookupReg1 and LookupReg2  input  ADDR_W  each  forwarding lookup indices.
REQ-015 SHALL have ports Hit1 and Hit2  output  1  each  pending write exists for the lookup index.
REQ-016 SHALL have ports FwdData1 and FwdData2  output  DATA_W  each  newest pending data for the lookup index.
REQ-017 SHALL have port Count  output  clog2(DEPTH)+1  number of occupied entries.

Function
REQ-018 SHALL assert InReady = (Count < DEPTH) && !Reset, from registered state only, with no combinational path from InValid.
REQ-019 SHALL accept a request at the rising edge where InValid && InReady.
REQ-020 SHALL discard an accepted request with InReg == 0 without enqueueing it; Count unchanged.
REQ-021 SHALL enqueue any other accepted request at the tail; FIFO order preserved.
REQ-022 SHALL drive RegWre = (Count != 0) && !WbStall && !Reset combinationally, with WriteReg/WriteData = head entry.
REQ-023 SHALL pop the head at the rising edge where RegWre is high; the register file samples the write on the falling edge of the same cycle.
REQ-024 SHALL give latency: request accepted at edge N into an empty queue -> RegWre high in the cycle following edge N.
REQ-025 SHALL, on simultaneous push and pop, perform both in the same edge; Count unchanged.
REQ-026 SHALL wrap read/write pointers modulo DEPTH; no entry is lost or duplicated across a wrap.
REQ-027 SHALL, while WbStall is high, hold head, pointers and outputs stable; pushes continue until full.
REQ-028 SHALL assert HitK combinationally when LookupRegK != 0 and any occupied entry has a matching index.
REQ-029 SHALL drive FwdDataK with the youngest matching occupied entry, and 0 when HitK is low.
REQ-030 SHALL exclude from lookup any request being accepted in the current cycle; it becomes visible after the edge.
REQ-031 SHALL keep the head entry visible to lookup during its pop cycle.

Reset
REQ-032 SHALL, on an edge with Reset high, clear pointers and Count to 0, discarding all pending entries, and accept no request.
REQ-033 SHALL hold RegWre, InReady, Hit1 and Hit2 at 0 during any cycle with Reset high, including reset mid-drain.
REQ-034 SHALL leave entry storage uncleared by reset; it is unobservable because Hit requires an occupied entry.

Structure
REQ-035 SHALL place DEPTH, DATA_W, ADDR_W defaults and the ZERO_REG constant (0) in a shared package, wbq_pkg.
REQ-036 SHALL implement youngest-match priority search in one sub-module, wbq_forward, instantiated once per lookup port.

Verification
REQ-037 SHALL cover: single push InReg=3, InData=0x12345678 into empty queue -> next cycle RegWre=1, WriteReg=3, WriteData=0x12345678, then Count=0.
REQ-038 SHALL cover: WbStall=1, push 4 entries (regs 1-4) -> InReady=0 at Count=4, 5th request not accepted; release WbStall -> writes to regs 1,2,3,4 in order on 4 consecutive cycles.
REQ-039 SHALL cover: WbStall=1, push reg 7 = 0xA then reg 7 = 0xB, LookupReg1=7 -> Hit1=1, FwdData1=0xB; LookupReg2=0 -> Hit2=0, FwdData2=0.
REQ-040 SHALL cover: push InReg=0, InData=0xFFFFFFFF -> accepted, Count stays 0, RegWre never asserted.
REQ-041 SHALL cover: 10 consecutive pushes with continuous drain and no stall -> Count stays 1 and write order matches push order across pointer wrap.
REQ-042 SHALL cover: Reset pulsed with Count=3 -> RegWre=0 in the reset cycle, Count=0 after, no stale Hit for prior regs.
